// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose
//   Turns a simple valid/ready command interface into APB transfers on up to
//   four slaves. Each slave owns one 4 KiB window. Slave n is decoded where
//   PADDR[31:12] == BASE_HI + n. A command to an address outside these windows
//   never reaches the bus and is answered with an error. An ACCESS phase that
//   waits TIMEOUT cycles without PREADY is aborted with an error.
//
// Parameters
//   TIMEOUT  maximum ACCESS-phase cycles without PREADY (must be >= 1)
//   BASE_HI  PADDR[31:12] of slave 0
//
// Ports
//   PCLK, PRESET              clock, asynchronous active-high reset
//   req_valid / req_ready     command handshake; ready only while idle
//   req_write                 1 = write, 0 = read
//   req_addr, req_wdata       byte address and write data
//   rsp_valid                 one-cycle response strobe
//   rsp_rdata, rsp_err        response data (0 for writes/errors) and error
//                             flag; both hold until the next response
//   PADDR, PWRITE, PWDATA     APB address, direction and write data
//   PSEL[3:0], PENABLE        one-hot slave select and access-phase strobe
//   PRDATA0..PRDATA3          per-slave read data
//   PREADY[3:0]               per-slave ready, bit n belongs to slave n
//------------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [19:0] BASE_HI = 20'h10000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    // command side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // response side
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // APB master side
    output logic [31:0] PADDR,
    output logic [3:0]  PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [3:0]  PREADY
);

    localparam int unsigned NUM_SLAVES = 4;

    // The wait counter only has to reach TIMEOUT, never exceed it.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    //--------------------------------------------------------------------------
    // Declarations
    //--------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;

    logic [31:0]        r_paddr;
    logic               r_pwrite;
    logic [31:0]        r_pwdata;
    logic [1:0]         r_slot;

    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_inc;

    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               w_rsp_load;
    logic [31:0]        w_rsp_rdata_next;
    logic               w_rsp_err_next;

    logic               w_accept;
    logic [19:0]        w_slot_offset;
    logic               w_mapped;
    logic               w_bus_active;
    logic               w_sel_ready;
    logic [31:0]        w_sel_rdata;
    logic               w_timeout;

    logic [32*NUM_SLAVES-1:0] w_prdata_flat;
    logic [31:0]              w_prdata [NUM_SLAVES];

    //--------------------------------------------------------------------------
    // Command acceptance and address decode
    //--------------------------------------------------------------------------
    // req_ready is gated by PRESET so nothing is offered while reset is held,
    // even though the state register already reads IDLE.
    assign req_ready = (r_state == ST_IDLE) && !PRESET;
    assign w_accept  = req_valid && req_ready;

    // Modular subtraction: everything below BASE_HI wraps to a large offset
    // and therefore decodes as unmapped along with everything above the map.
    assign w_slot_offset = req_addr[31:12] - BASE_HI;
    assign w_mapped      = (w_slot_offset < 20'(NUM_SLAVES));

    //--------------------------------------------------------------------------
    // Slave read-data / ready selection
    //--------------------------------------------------------------------------
    assign w_prdata_flat = {PRDATA3, PRDATA2, PRDATA1, PRDATA0};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign w_prdata[gi] = w_prdata_flat[gi*32 +: 32];
            // Select is decoded from state, so an asynchronous reset of the
            // state register drops PSEL at once.
            assign PSEL[gi]     = w_bus_active && (r_slot == 2'(gi));
        end
    endgenerate

    // Only the addressed slave's PREADY is ever looked at.
    assign w_sel_ready = PREADY[r_slot];
    assign w_sel_rdata = w_prdata[r_slot];

    //--------------------------------------------------------------------------
    // Wait counter
    //--------------------------------------------------------------------------
    assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);
    // Abort on the ACCESS cycle whose missing PREADY would bring the count to
    // TIMEOUT, so exactly TIMEOUT ACCESS cycles elapse before giving up.
    assign w_timeout = (w_wait_cnt_inc == TIMEOUT_CNT);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !w_sel_ready) begin
            r_wait_cnt <= w_wait_cnt_inc;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state and response capture
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_rsp_load       = 1'b0;
        w_rsp_rdata_next = 32'h0;
        w_rsp_err_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_mapped) begin
                        w_state_next = ST_SETUP;
                    end else begin
                        // Unmapped: answer straight away, bus untouched.
                        w_state_next   = ST_RESP;
                        w_rsp_load     = 1'b1;
                        w_rsp_err_next = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end

            ST_ACCESS: begin
                // PREADY is checked before the timeout so a slave that becomes
                // ready on the last allowed cycle still completes normally.
                if (w_sel_ready) begin
                    w_state_next     = ST_RESP;
                    w_rsp_load       = 1'b1;
                    w_rsp_rdata_next = r_pwrite ? 32'h0 : w_sel_rdata;
                end else if (w_timeout) begin
                    w_state_next   = ST_RESP;
                    w_rsp_load     = 1'b1;
                    w_rsp_err_next = 1'b1;
                end
            end

            ST_RESP: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Command registers: loaded only on acceptance, so they stay stable for
    // the whole transfer and keep their value while idle or responding.
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_paddr  <= 32'h0;
            r_pwrite <= 1'b0;
            r_pwdata <= 32'h0;
            r_slot   <= 2'd0;
        end else if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_slot   <= w_slot_offset[1:0];
        end
    end

    //--------------------------------------------------------------------------
    // Response registers: written only when entering RESP, so the last
    // response stays visible until the next one.
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_err   <= w_rsp_err_next;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign PENABLE      = (r_state == ST_ACCESS);
    assign PADDR        = r_paddr;
    assign PWRITE       = r_pwrite;
    assign PWDATA       = r_pwdata;

    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
//------------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge (TIMEOUT = 4). A directed table
// covers the named scenarios, a hand-written sequence covers reset during
// ACCESS, and randomized commands are checked against a transaction-level
// model that derives latency, select and response from the address map and
// the slave's wait count.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master_bridge;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [19:0] BASE_HI = 20'h10000;
    localparam int          N_RAND  = 40;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA0 = 32'h0;
    logic [31:0] PRDATA1 = 32'h0;
    logic [31:0] PRDATA2 = 32'h0;
    logic [31:0] PRDATA3 = 32'h0;
    logic [3:0]  PREADY = 4'h0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .TIMEOUT (TIMEOUT),
        .BASE_HI (BASE_HI)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA0   (PRDATA0),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PRDATA3   (PRDATA3),
        .PREADY    (PREADY)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;

    // One command plus the slave's behaviour and the expected outcome.
    // delay = ACCESS cycles the selected slave waits before PREADY.
    // exp_lat = cycles from the accept cycle to the rsp_valid cycle.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] sdata;
        logic [3:0]  foreign;
        logic        hold;
        logic [3:0]  exp_psel;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: which window the address falls in, how
    // long the slave makes us wait, and whether the wait budget is exceeded.
    function automatic vec_t model(input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int delay,
                                   input logic [31:0] sdata, input logic [3:0] foreign,
                                   input logic hold);
        vec_t v;
        int   slot;
        int   access_cycles;
        bit   ok;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay;
        v.sdata = sdata; v.foreign = foreign; v.hold = hold;
        slot = int'(addr[31:12]) - int'(BASE_HI);
        if (slot < 0 || slot > 3) begin
            v.exp_psel  = 4'b0000;
            v.exp_lat   = 1;
            v.exp_err   = 1'b1;
            v.exp_rdata = 32'h0;
        end else begin
            ok            = (delay + 1) <= int'(TIMEOUT);
            access_cycles = ok ? delay + 1 : int'(TIMEOUT);
            v.exp_psel    = 4'(1 << slot);
            v.exp_lat     = 2 + access_cycles;
            v.exp_err     = !ok;
            v.exp_rdata   = (ok && !wr) ? sdata : 32'h0;
        end
        return v;
    endfunction

    // Called just after a negedge of an IDLE cycle; returns just after the
    // negedge of the RESP cycle.
    task automatic run_txn(input vec_t v, input string tag);
        logic [3:0] foreign_m;
        foreign_m = v.foreign & ~v.exp_psel;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".hold_rdata"}, rsp_rdata, last_rdata);
        chk({tag, ".hold_err"}, 32'(rsp_err), 32'(last_err));
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        PRDATA0   = v.exp_psel[0] ? v.sdata : $urandom();
        PRDATA1   = v.exp_psel[1] ? v.sdata : $urandom();
        PRDATA2   = v.exp_psel[2] ? v.sdata : $urandom();
        PRDATA3   = v.exp_psel[3] ? v.sdata : $urandom();
        PREADY    = foreign_m;
        for (int k = 1; k <= v.exp_lat; k++) begin
            @(negedge PCLK);
            if (!v.hold) req_valid = 1'b0;
            chk({tag, ".paddr"}, PADDR, v.addr);
            chk({tag, ".pwrite"}, 32'(PWRITE), 32'(v.wr));
            chk({tag, ".pwdata"}, PWDATA, v.wdata);
            if (k < v.exp_lat) begin
                chk({tag, ".rsp_valid_low"}, 32'(rsp_valid), 32'd0);
                chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
                chk({tag, ".psel"}, 32'(PSEL), 32'(v.exp_psel));
                chk({tag, ".penable"}, 32'(PENABLE), 32'((v.exp_psel != 4'b0) && (k >= 2)));
            end else begin
                chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, ".psel_resp"}, 32'(PSEL), 32'd0);
                chk({tag, ".penable_resp"}, 32'(PENABLE), 32'd0);
                chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
                chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
            end
            // Slave drives PREADY on ACCESS cycle number delay+1 (cycle k is
            // ACCESS cycle k-1 when the transfer is mapped).
            PREADY = foreign_m | (((k - 1) == v.delay + 1) ? v.exp_psel : 4'b0000);
        end
        PREADY     = 4'b0000;
        last_rdata = v.exp_rdata;
        last_err   = v.exp_err;
        $display("txn %s: %s addr=0x%08h psel=%b lat=%0d err=%0d rdata=0x%08h",
                 tag, v.wr ? "WR" : "RD", v.addr, v.exp_psel, v.exp_lat, v.exp_err, rsp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 ns");
        $fatal(1);
    end

    initial begin
        //                wr    addr          wdata         dly  sdata         foreign hold  psel     lat err   rdata
        tbl[0]  = '{1'b1, 32'h1000_1000, 32'h0000_0001, 0,   32'hFFFF_FFFF, 4'h0, 1'b0, 4'b0010, 3, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h1000_2014, 32'h0,         3,   32'h3132_3334, 4'h0, 1'b0, 4'b0100, 6, 1'b0, 32'h3132_3334};
        tbl[2]  = '{1'b0, 32'h2000_0000, 32'h0,         0,   32'h1111_1111, 4'h0, 1'b0, 4'b0000, 1, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 32'h1000_3000, 32'hCAFE_0003, 100, 32'hFFFF_FFFF, 4'h0, 1'b0, 4'b1000, 6, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 32'h1000_0040, 32'h0,         0,   32'hA5A5_0001, 4'h0, 1'b0, 4'b0001, 3, 1'b0, 32'hA5A5_0001};
        tbl[5]  = '{1'b0, 32'h1000_3FFC, 32'h0,         3,   32'hDEAD_BEEF, 4'h0, 1'b0, 4'b1000, 6, 1'b0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b1, 32'h1000_0008, 32'h55AA_55AA, 1,   32'h7777_7777, 4'hE, 1'b1, 4'b0001, 4, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h1000_2000, 32'h0,         2,   32'h1234_5678, 4'hB, 1'b0, 4'b0100, 5, 1'b0, 32'h1234_5678};
        tbl[8]  = '{1'b0, 32'h0FFF_F000, 32'h0,         0,   32'h2222_2222, 4'h0, 1'b0, 4'b0000, 1, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 32'h1000_4000, 32'h0BAD_0BAD, 0,   32'h3333_3333, 4'h0, 1'b0, 4'b0000, 1, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h1000_1004, 32'h0,         4,   32'h0BAD_F00D, 4'h0, 1'b0, 4'b0010, 6, 1'b1, 32'h0};

        // ---------------- reset state ----------------
        #2 PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.psel", 32'(PSEL), 32'd0);
        chk("rst.penable", 32'(PENABLE), 32'd0);
        chk("rst.pwrite", 32'(PWRITE), 32'd0);
        chk("rst.paddr", PADDR, 32'h0);
        chk("rst.pwdata", PWDATA, 32'h0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        PRESET = 1'b0;
        #1;
        chk("rst.ready_after_release", 32'(req_ready), 32'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge PCLK);
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end
        req_valid = 1'b0;

        // ---------------- reset during ACCESS of a slave 0 read ----------------
        @(negedge PCLK);
        chk("mid.ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000_0010; req_wdata = 32'h0;
        PRDATA0 = 32'h600D_0000; PREADY = 4'b0000;
        @(negedge PCLK);
        req_valid = 1'b0;
        chk("mid.setup_psel", 32'(PSEL), 32'b0001);
        chk("mid.setup_penable", 32'(PENABLE), 32'd0);
        @(negedge PCLK);
        chk("mid.access_psel", 32'(PSEL), 32'b0001);
        chk("mid.access_penable", 32'(PENABLE), 32'd1);
        #1 PRESET = 1'b1;
        #1;
        chk("mid.async_psel", 32'(PSEL), 32'd0);
        chk("mid.async_penable", 32'(PENABLE), 32'd0);
        chk("mid.ready_in_reset", 32'(req_ready), 32'd0);
        PREADY = 4'b0001;
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("mid.ready_after", 32'(req_ready), 32'd1);
        PREADY = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            chk("mid.no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid.psel_idle", 32'(PSEL), 32'd0);
            chk("mid.ready_idle", 32'(req_ready), 32'd1);
        end
        chk("mid.rdata_cleared", rsp_rdata, 32'h0);
        chk("mid.err_cleared", 32'(rsp_err), 32'd0);
        $display("txn mid_reset: RD addr=0x10000010 aborted by reset, no response");
        last_rdata = 32'h0;
        last_err   = 1'b0;

        // ---------------- randomized commands ----------------
        for (int i = 0; i < N_RAND; i++) begin
            vec_t        v;
            logic [19:0] hi;
            logic [31:0] addr;
            hi   = BASE_HI - 20'd1 + 20'($urandom_range(0, 5));
            addr = {hi, 12'($urandom())};
            v = model(1'($urandom()), addr, $urandom(), int'($urandom_range(0, 6)),
                      $urandom(), 4'($urandom()), (i < N_RAND - 1) ? 1'($urandom()) : 1'b0);
            @(negedge PCLK);
            run_txn(v, $sformatf("rnd%0d", i));
        end
        req_valid = 1'b0;
        @(negedge PCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
